// File: rtl/vid_fill_if.sv
// Processor-side register bus, frame-buffer write bus and vidmem write port of vid_fill.
// The irq wire exists only when VID_FILL_IRQ_EN is defined.
interface vid_fill_if;
  logic        reg_en;
  logic        reg_wr;
  logic [1:0]  reg_adr;
  logic [31:0] reg_din;
  logic [31:0] reg_dout;
  logic        cpu_en;
  logic        cpu_wr;
  logic [14:0] cpu_adr;
  logic [31:0] cpu_din;
  logic        mem_en;
  logic [14:0] mem_adr;
  logic [31:0] mem_dout;
`ifdef VID_FILL_IRQ_EN
  logic        irq;

  modport master (
    output reg_en, reg_wr, reg_adr, reg_din, cpu_en, cpu_wr, cpu_adr, cpu_din,
    input  reg_dout, mem_en, mem_adr, mem_dout, irq
  );
  modport slave (
    input  reg_en, reg_wr, reg_adr, reg_din, cpu_en, cpu_wr, cpu_adr, cpu_din,
    output reg_dout, mem_en, mem_adr, mem_dout, irq
  );
`else
  modport master (
    output reg_en, reg_wr, reg_adr, reg_din, cpu_en, cpu_wr, cpu_adr, cpu_din,
    input  reg_dout, mem_en, mem_adr, mem_dout
  );
  modport slave (
    input  reg_en, reg_wr, reg_adr, reg_din, cpu_en, cpu_wr, cpu_adr, cpu_din,
    output reg_dout, mem_en, mem_adr, mem_dout
  );
`endif
endinterface

// File: rtl/vid_fill.sv
// Rectangle-fill engine and vidmem write-port arbiter; processor writes always win the port.
// Optional VID_FILL_IRQ_EN adds a registered completion interrupt mirrored in CTRL bit2.
module vid_fill #(
  parameter int unsigned LINES = 768,
  parameter int unsigned WPL   = 32
) (
  input  logic clk,
  input  logic rst_n,
  vid_fill_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e      state_q, state_d;
  logic [31:0] rect_q, pat_q;
  logic        done_q, done_d;
  logic [4:0]  cur_x_q, cur_x_d;
  logic [10:0] cur_y_q, cur_y_d;
  logic [5:0]  cnt_w_q, cnt_w_d;
  logic [9:0]  cnt_h_q, cnt_h_d;
  logic        mem_en_q, mem_en_d;
  logic [14:0] mem_adr_q, mem_adr_d;
  logic [31:0] mem_dout_q, mem_dout_d;

  logic        reg_we, ctrl_we, start, abort, clr_done;
  logic        cpu_take, busy, line_end, suppress;
  logic [4:0]  rx;
  logic [9:0]  ry, rh;
  logic [5:0]  rw;

  assign reg_we   = bus.reg_en & bus.reg_wr;
  assign ctrl_we  = reg_we & (bus.reg_adr == 2'd0);
  assign start    = ctrl_we & bus.reg_din[0];
  assign abort    = ctrl_we & bus.reg_din[1];
  assign clr_done = ctrl_we & bus.reg_din[2];

  assign rx = rect_q[4:0];
  assign ry = rect_q[14:5];
  assign rw = rect_q[21:16];
  assign rh = rect_q[31:22];

  // Address bits 14:13 both set means line >= 768: never a visible processor write.
  assign cpu_take = bus.cpu_en & bus.cpu_wr & ~(bus.cpu_adr[14] & bus.cpu_adr[13]);
  assign busy     = (state_q != StIdle);
  assign line_end = (cnt_w_q == 6'd1) || (cur_x_q == 5'(WPL - 1));
  assign suppress = (cur_y_q >= 11'(LINES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (start) state_d = ((rw == 6'd0) || (rh == 10'd0)) ? StFinish : StRun;
        StRun:    if (!cpu_take && line_end && (cnt_h_q == 10'd1)) state_d = StFinish;
        StFinish: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    cnt_w_d    = cnt_w_q;
    cnt_h_d    = cnt_h_q;
    mem_en_d   = 1'b0;
    mem_adr_d  = mem_adr_q;
    mem_dout_d = mem_dout_q;
    done_d     = clr_done ? 1'b0 : done_q;
    if (cpu_take) begin
      mem_en_d   = 1'b1;
      mem_adr_d  = bus.cpu_adr;
      mem_dout_d = bus.cpu_din;
    end
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          cur_x_d = rx;
          cur_y_d = {1'b0, ry};
          cnt_w_d = rw;
          cnt_h_d = rh;
        end
      end
      StRun: begin
        // Counters advance even for suppressed lines so the busy time stays predictable.
        if (!cpu_take && !abort) begin
          if (!suppress) begin
            mem_en_d   = 1'b1;
            mem_adr_d  = {cur_y_q[9:0], cur_x_q};
            mem_dout_d = pat_q;
          end
          if (line_end) begin
            cur_x_d = rx;
            cur_y_d = cur_y_q + 11'd1;
            cnt_w_d = rw;
            cnt_h_d = cnt_h_q - 10'd1;
          end else begin
            cur_x_d = cur_x_q + 5'd1;
            cnt_w_d = cnt_w_q - 6'd1;
          end
        end
      end
      StFinish: if (!abort) done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rect_q     <= '0;
      pat_q      <= '0;
      done_q     <= 1'b0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      cnt_w_q    <= '0;
      cnt_h_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_adr_q  <= '0;
      mem_dout_q <= '0;
    end else begin
      if (reg_we && !busy && (bus.reg_adr == 2'd1)) rect_q <= bus.reg_din;
      if (reg_we && !busy && (bus.reg_adr == 2'd2)) pat_q  <= bus.reg_din;
      done_q     <= done_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      cnt_w_q    <= cnt_w_d;
      cnt_h_q    <= cnt_h_d;
      mem_en_q   <= mem_en_d;
      mem_adr_q  <= mem_adr_d;
      mem_dout_q <= mem_dout_d;
    end
  end

  assign bus.mem_en   = mem_en_q;
  assign bus.mem_adr  = mem_adr_q;
  assign bus.mem_dout = mem_dout_q;

`ifdef VID_FILL_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = clr_done ? 1'b0 : irq_q;
    if ((state_d == StFinish) && (state_q != StFinish)) irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.irq = irq_q;
`endif

  always_comb begin
    bus.reg_dout = '0;
    unique case (bus.reg_adr)
      2'd0: begin
        bus.reg_dout[1:0] = {done_q, busy};
`ifdef VID_FILL_IRQ_EN
        bus.reg_dout[2] = irq_q;
`endif
      end
      2'd1:    bus.reg_dout = rect_q;
      2'd2:    bus.reg_dout = pat_q;
      default: bus.reg_dout = '0;
    endcase
  end

endmodule
